// File: rtl/db_responder.sv
// Memory-side responder for the RK8E single-cycle data-break handshake.
// Holds the CPU and performs one write, read, or read-increment-write per break.
module db_responder #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_break,
  input  logic        to_disk,
  input  logic        inc_mode,
  input  logic [0:14] dmaAddr,
  input  logic [0:11] dmaDOUT,
  output logic [0:11] dmaDIN,
  output logic        break_in_prog,
  output logic        break_done,
  output logic        inc_ovf,
  input  logic        grant_ok,
  output logic        cpu_hold,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [0:11] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RD_WAIT, INC, DONE} state_t;

  localparam logic [1:0] LAST = 2'(READ_LAT - 1);

  state_t      state, state_nxt;
  logic        req_rd, req_rd_nxt;
  logic        req_inc, req_inc_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [0:11] din_nxt, wdata_nxt;
  logic [0:14] addr_nxt;
  logic        we_nxt, re_nxt, done_nxt, ovf_nxt, busy_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_rd        <= 1'b0;
      req_inc       <= 1'b0;
      cnt           <= '0;
      dmaDIN        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      break_done    <= 1'b0;
      inc_ovf       <= 1'b0;
      break_in_prog <= 1'b0;
      cpu_hold      <= 1'b0;
    end else begin
      state         <= state_nxt;
      req_rd        <= req_rd_nxt;
      req_inc       <= req_inc_nxt;
      cnt           <= cnt_nxt;
      dmaDIN        <= din_nxt;
      mem_addr      <= addr_nxt;
      mem_wdata     <= wdata_nxt;
      mem_we        <= we_nxt;
      mem_re        <= re_nxt;
      break_done    <= done_nxt;
      inc_ovf       <= ovf_nxt;
      break_in_prog <= busy_nxt;
      cpu_hold      <= busy_nxt;
    end
  end

  // Outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    state_nxt   = state;
    req_rd_nxt  = req_rd;
    req_inc_nxt = req_inc;
    cnt_nxt     = cnt;
    din_nxt     = dmaDIN;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    we_nxt      = 1'b0;
    re_nxt      = 1'b0;
    done_nxt    = 1'b0;
    ovf_nxt     = inc_ovf;

    unique case (state)
      IDLE: begin
        if (data_break) begin
          addr_nxt    = dmaAddr;
          wdata_nxt   = dmaDOUT;
          req_rd_nxt  = to_disk | inc_mode;
          req_inc_nxt = inc_mode;
          ovf_nxt     = 1'b0;
          if (grant_ok) begin
            state_nxt = ACCESS;
            re_nxt    = to_disk | inc_mode;
            we_nxt    = ~(to_disk | inc_mode);
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!data_break) begin
          state_nxt = IDLE;
        end else if (grant_ok) begin
          state_nxt = ACCESS;
          re_nxt    = req_rd;
          we_nxt    = ~req_rd;
        end
      end
      ACCESS: begin
        if (req_rd) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = '0;
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt == LAST) begin
          din_nxt = mem_rdata;
          if (req_inc) begin
            state_nxt = INC;
            we_nxt    = 1'b1;
            wdata_nxt = mem_rdata + 12'd1;
            ovf_nxt   = (mem_rdata == 12'o7777);
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      INC: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_db_responder.sv
// Scoreboard bench for db_responder: READ_LAT=1 and READ_LAT=3 instances
// against behavioural memories; a monitor pops expected breaks as they complete.
module tb_db_responder;

  typedef struct {
    int          id;
    int          kind;   // 0 write, 1 read, 2 increment
    logic [0:14] addr;
    logic [0:11] wdata;
    logic [0:11] din;
    logic        ovf;
    int          lat;    // cycles from first strobe to break_done
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, preload, grant_ok, to_disk, inc_mode, db1, db3;
  logic [0:14] dma_addr;
  logic [0:11] dma_dout;

  logic [0:11] din1, wdata1, rdata1, din3, wdata3, rdata3, p1, p2;
  logic [0:14] addr1, addr3;
  logic        bip1, done1, ovf1, hold1, we1, re1;
  logic        bip3, done3, ovf3, hold3, we3, re3;

  logic [0:11] mem1 [0:32767];
  logic [0:11] mem3 [0:32767];

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   busy [2];
  int   start [2];

  always #5 clk = ~clk;

  db_responder #(.READ_LAT(1)) u1 (
    .clk(clk), .reset(reset), .data_break(db1), .to_disk(to_disk), .inc_mode(inc_mode),
    .dmaAddr(dma_addr), .dmaDOUT(dma_dout), .dmaDIN(din1), .break_in_prog(bip1),
    .break_done(done1), .inc_ovf(ovf1), .grant_ok(grant_ok), .cpu_hold(hold1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1), .mem_re(re1), .mem_rdata(rdata1)
  );

  db_responder #(.READ_LAT(3)) u3 (
    .clk(clk), .reset(reset), .data_break(db3), .to_disk(to_disk), .inc_mode(inc_mode),
    .dmaAddr(dma_addr), .dmaDOUT(dma_dout), .dmaDIN(din3), .break_in_prog(bip3),
    .break_done(done3), .inc_ovf(ovf3), .grant_ok(grant_ok), .cpu_hold(hold3),
    .mem_addr(addr3), .mem_wdata(wdata3), .mem_we(we3), .mem_re(re3), .mem_rdata(rdata3)
  );

  always @(posedge clk) begin
    if (preload) begin
      mem1[15'o01234] <= 12'o7070;
      mem1[15'o02000] <= 12'o7777;
      mem1[15'o02001] <= 12'o0041;
      mem1[15'o02002] <= 12'o0100;
      mem3[15'o01234] <= 12'o7070;
      mem3[15'o03000] <= 12'o0041;
    end else begin
      if (we1) mem1[addr1] <= wdata1;
      if (re1) rdata1 <= mem1[addr1];
      if (we3) mem3[addr3] <= wdata3;
      if (re3) p1 <= mem3[addr3];
      p2     <= p1;
      rdata3 <= p2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0o expected %0o", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  task automatic mon(input int id, input logic we, input logic re, input logic done,
                     input logic bip, input logic [0:14] addr, input logic [0:11] wdata,
                     input logic [0:11] din, input logic ovf);
    exp_t e;
    logic have;
    have = (sb.size() > 0) && (sb[0].id == id);
    if (have) e = sb[0];
    if (we && re) fail_now("strobe_overlap");
    if ((we || re) && busy[id] == 0) begin
      busy[id]  = 1;
      start[id] = cyc;
    end
    if (re && have) chk("re_addr", 32'(addr), 32'(e.addr));
    if (we) begin
      if (!have || e.kind == 1) fail_now("spurious_we");
      else begin
        chk("we_addr", 32'(addr), 32'(e.addr));
        chk("we_data", 32'(wdata), 32'(e.wdata));
      end
    end
    if (done) begin
      if (!have) fail_now("spurious_done");
      else begin
        void'(sb.pop_front());
        chk("latency", 32'(cyc - start[id]), 32'(e.lat));
        if (e.kind != 0) chk("din", 32'(din), 32'(e.din));
        chk("inc_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    if (!bip) busy[id] = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, we1, re1, done1, bip1, addr1, wdata1, din1, ovf1);
    mon(1, we3, re3, done3, bip3, addr3, wdata3, din3, ovf3);
  end

  task automatic wait_done(input int id);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if ((id == 0) ? done1 : done3) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_now("done_timeout");
  endtask

  task automatic brk(input int id, input int kind, input logic [0:14] a, input logic [0:11] d,
                     input logic [0:11] din_e, input logic [0:11] wd_e, input logic ovf_e);
    exp_t e;
    int l;
    l = (id == 0) ? 1 : 3;
    e = '{id, kind, a, wd_e, din_e, ovf_e, (kind == 0) ? 1 : (kind == 1) ? 1 + l : 2 + l};
    sb.push_back(e);
    @(negedge clk);
    dma_addr = a;
    dma_dout = d;
    to_disk  = (kind == 1);
    inc_mode = (kind == 2);
    if (id == 0) db1 = 1'b1; else db3 = 1'b1;
    @(negedge clk);
    // scramble request inputs once accepted; they must not be re-sampled
    dma_addr = a ^ 15'o77777;
    dma_dout = ~d;
    to_disk  = ~to_disk;
    inc_mode = ~inc_mode;
    wait_done(id);
    db1 = 1'b0;
    db3 = 1'b0;
  endtask

  task automatic check_reset1(input string tag);
    chk({tag, "_din"}, 32'(din1), 0);
    chk({tag, "_addr"}, 32'(addr1), 0);
    chk({tag, "_wdata"}, 32'(wdata1), 0);
    chk({tag, "_ctl"}, 32'({we1, re1, bip1, done1, ovf1, hold1}), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; preload = 1'b1; grant_ok = 1'b1; to_disk = 1'b0; inc_mode = 1'b0;
    db1 = 1'b0; db3 = 1'b0; dma_addr = '0; dma_dout = '0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    check_reset1("reset");
    chk("reset_u3", 32'({din3, addr3, we3, re3, bip3, hold3}), 0);
    reset = 1'b0;

    brk(0, 0, 15'o12345, 12'o4321, 12'o0000, 12'o4321, 1'b0);
    brk(0, 1, 15'o01234, 12'o0000, 12'o7070, 12'o0000, 1'b0);
    brk(0, 2, 15'o02000, 12'o0000, 12'o7777, 12'o0000, 1'b1);
    brk(0, 2, 15'o02001, 12'o0000, 12'o0041, 12'o0042, 1'b0);
    brk(0, 1, 15'o12345, 12'o0000, 12'o4321, 12'o0000, 1'b0);
    brk(0, 1, 15'o02000, 12'o0000, 12'o0000, 12'o0000, 1'b0);
    brk(1, 1, 15'o01234, 12'o0000, 12'o7070, 12'o0000, 1'b0);
    brk(1, 2, 15'o03000, 12'o0000, 12'o0041, 12'o0042, 1'b0);

    // held off by grant_ok
    @(negedge clk);
    grant_ok = 1'b0; to_disk = 1'b0; inc_mode = 1'b0;
    dma_addr = 15'o00007; dma_dout = 12'o1234; db1 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("wait_hold", 32'(hold1), 1);
      chk("wait_strobe", 32'(we1 | re1), 0);
    end
    sb.push_back('{0, 0, 15'o00007, 12'o1234, 12'o0000, 1'b0, 1});
    grant_ok = 1'b1;
    @(negedge clk);
    chk("grant_access", 32'(we1), 1);
    wait_done(0);
    db1 = 1'b0;

    // request withdrawn while waiting
    @(negedge clk);
    grant_ok = 1'b0; dma_addr = 15'o00010; db1 = 1'b1;
    repeat (3) @(negedge clk);
    db1 = 1'b0;
    @(negedge clk);
    chk("drop_idle", 32'({bip1, hold1}), 0);
    repeat (3) begin
      @(negedge clk);
      chk("drop_no_done", 32'(done1), 0);
    end
    grant_ok = 1'b1;

    // reset during RD_WAIT of an increment, request still held
    @(negedge clk);
    dma_addr = 15'o02002; to_disk = 1'b0; inc_mode = 1'b1; db1 = 1'b1;
    @(negedge clk);
    chk("rst_pre_re", 32'(re1), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset1("midreset");
    sb.push_back('{0, 2, 15'o02002, 12'o0101, 12'o0100, 1'b0, 3});
    reset = 1'b0;
    wait_done(0);
    db1 = 1'b0;

    // back-to-back breaks with data_break held high
    @(negedge clk);
    dma_addr = 15'o00020; dma_dout = 12'o0111; to_disk = 1'b0; inc_mode = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back('{0, 0, 15'o00020, 12'o0111, 12'o0000, 1'b0, 1});
    db1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(0);
      if (k < 2) begin
        @(negedge clk);
        chk("gap_idle", 32'({bip1, we1}), 0);
        @(negedge clk);
        chk("gap_access", 32'(we1), 1);
      end
    end
    db1 = 1'b0;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
